// File: rtl/display_scan_scheduler.sv
// Timed scan sequencer for a multiplexed 3-digit 7-segment display shared by two
// value sources through a frame-granular round-robin arbiter.
module display_scan_scheduler #(
   parameter int PRESC = 50000,
   parameter int DEAD  = 16,
   parameter int HOLD  = 64,
   parameter int LZB   = 1
) (
   input  logic       clock,
   input  logic       zera_n,
   input  logic       req_a,
   input  logic [7:0] valor_a,
   input  logic       req_b,
   input  logic [7:0] valor_b,
   output logic       gnt_a,
   output logic       gnt_b,
   output logic [7:0] numero,
   output logic [1:0] digit_sel,
   output logic [3:0] enable_n,
   output logic       fim_quadro
);

   localparam int CNT_MAX = (PRESC > DEAD) ? PRESC : DEAD;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int FW      = $clog2(HOLD + 1);

   localparam logic [CW-1:0] PRESC_LAST = CW'(PRESC - 1);
   localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD - 1);
   localparam logic [FW-1:0] HOLD_V     = FW'(HOLD);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARB,
      S_ON,
      S_GAP
   } state_t;

   state_t          r_state,     w_state_nx;
   logic [CW-1:0]   r_cnt,       w_cnt_nx;
   logic [1:0]      r_digit,     w_digit_nx;
   logic            r_gnt_a,     w_gnt_a_nx;
   logic            r_gnt_b,     w_gnt_b_nx;
   logic [7:0]      r_numero,    w_numero_nx;
   logic [3:0]      r_enable_n,  w_enable_n_nx;
   logic            r_fim,       w_fim_nx;
   logic [FW-1:0]   r_frame_cnt, w_frame_cnt_nx;
   logic            r_last_b,    w_last_b_nx;

   logic            w_has_owner;
   logic            w_owner_req;
   logic            w_other_req;
   logic            w_hold_done;
   logic            w_win_a;
   logic            w_win_b;
   logic            w_keep;

   // Active-low enable for one digit slot, honouring leading-zero blanking.
   function automatic logic [3:0] digit_enable(input logic [1:0] digit, input logic [7:0] value);
      logic       blank;
      logic [3:0] en;
      blank = (LZB != 0) &&
              (((digit == 2'd2) && (value < 8'd100)) || ((digit == 2'd1) && (value < 8'd10)));
      en = 4'b1111;
      if (!blank) en[digit] = 1'b0;
      return en;
   endfunction

   // Arbitration decision, only consumed in the ARB state.
   always_comb begin
      w_has_owner = r_gnt_a | r_gnt_b;
      w_owner_req = (r_gnt_a & req_a) | (r_gnt_b & req_b);
      w_other_req = (r_gnt_a & req_b) | (r_gnt_b & req_a);
      w_hold_done = (r_frame_cnt >= HOLD_V);
      w_keep      = 1'b0;
      w_win_a     = 1'b0;
      w_win_b     = 1'b0;
      if (w_has_owner) begin
         if (w_owner_req && !(w_hold_done && w_other_req)) begin
            w_keep  = 1'b1;
            w_win_a = r_gnt_a;
            w_win_b = r_gnt_b;
         end else if (w_other_req) begin
            w_win_a = r_gnt_b;
            w_win_b = r_gnt_a;
         end
      end else if (req_a && req_b) begin
         w_win_a = r_last_b;
         w_win_b = !r_last_b;
      end else begin
         w_win_a = req_a;
         w_win_b = req_b;
      end
   end

   // NOTE: every signal gets its hold value first so no path through the case infers a latch.
   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_digit_nx     = r_digit;
      w_gnt_a_nx     = r_gnt_a;
      w_gnt_b_nx     = r_gnt_b;
      w_numero_nx    = r_numero;
      w_frame_cnt_nx = r_frame_cnt;
      w_last_b_nx    = r_last_b;

      unique case (r_state)
         S_IDLE: begin
            if (req_a || req_b) w_state_nx = S_ARB;
         end
         S_ARB: begin
            w_cnt_nx   = '0;
            w_digit_nx = 2'd0;
            if (w_win_a || w_win_b) begin
               w_state_nx     = S_ON;
               w_gnt_a_nx     = w_win_a;
               w_gnt_b_nx     = w_win_b;
               w_numero_nx    = w_win_a ? valor_a : valor_b;
               w_last_b_nx    = w_win_b;
               // A kept grant that already reached HOLD restarts its count.
               w_frame_cnt_nx = (w_keep && !w_hold_done) ? r_frame_cnt : '0;
            end else begin
               w_state_nx = S_IDLE;
               w_gnt_a_nx = 1'b0;
               w_gnt_b_nx = 1'b0;
            end
         end
         S_ON: begin
            if (r_cnt == PRESC_LAST) begin
               w_state_nx = S_GAP;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         S_GAP: begin
            if (r_cnt == DEAD_LAST) begin
               w_cnt_nx = '0;
               if (r_digit == 2'd2) begin
                  w_state_nx     = S_ARB;
                  w_digit_nx     = 2'd0;
                  w_frame_cnt_nx = (r_frame_cnt == HOLD_V) ? r_frame_cnt : r_frame_cnt + FW'(1);
               end else begin
                  w_state_nx = S_ON;
                  w_digit_nx = r_digit + 2'd1;
               end
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      // Outputs are computed from the next state so they register on the same edge.
      w_enable_n_nx = (w_state_nx == S_ON) ? digit_enable(w_digit_nx, w_numero_nx) : 4'b1111;
      w_fim_nx      = (w_state_nx == S_GAP) && (w_digit_nx == 2'd2) && (w_cnt_nx == DEAD_LAST);
   end

   // NOTE: non-blocking assignments so every register samples the pre-edge values together.
   always_ff @(posedge clock) begin
      if (!zera_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_digit     <= 2'd0;
         r_gnt_a     <= 1'b0;
         r_gnt_b     <= 1'b0;
         r_numero    <= 8'd0;
         r_enable_n  <= 4'b1111;
         r_fim       <= 1'b0;
         r_frame_cnt <= '0;
         r_last_b    <= 1'b1;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_digit     <= w_digit_nx;
         r_gnt_a     <= w_gnt_a_nx;
         r_gnt_b     <= w_gnt_b_nx;
         r_numero    <= w_numero_nx;
         r_enable_n  <= w_enable_n_nx;
         r_fim       <= w_fim_nx;
         r_frame_cnt <= w_frame_cnt_nx;
         r_last_b    <= w_last_b_nx;
      end
   end

   assign gnt_a      = r_gnt_a;
   assign gnt_b      = r_gnt_b;
   assign numero     = r_numero;
   assign digit_sel  = r_digit;
   assign enable_n   = r_enable_n;
   assign fim_quadro = r_fim;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: directed scenarios plus random traffic, each cycle
// compared against a frame-position model of the scan and arbitration rules.
module tb_display_scan_scheduler;

   localparam int P     = 4;
   localparam int D     = 2;
   localparam int H     = 2;
   localparam int SLOT  = P + D;
   localparam int FRAME = 1 + 3 * SLOT;

   logic       clock = 1'b0;
   logic       zera_n = 1'b0;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;
   logic [7:0] valor_a = 8'd0;
   logic [7:0] valor_b = 8'd0;

   logic       gnt_a, gnt_b, fim_quadro;
   logic [7:0] numero;
   logic [1:0] digit_sel;
   logic [3:0] enable_n;

   logic       gnt_a0, gnt_b0, fim_quadro0;
   logic [7:0] numero0;
   logic [1:0] digit_sel0;
   logic [3:0] enable_n0;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   // Model: busy=0 means idle; pos 0 is the arbitration cycle, 1..FRAME-1 the scan.
   bit         m_busy  = 0;
   int         m_pos   = 0;
   int         m_owner = 0;   // 0 none, 1 A, 2 B
   int         m_shown = 0;   // frames granted to the current owner, including this one
   int         m_last  = 2;
   logic [7:0] m_num   = 8'd0;

   always #5 clock = ~clock;

   display_scan_scheduler #(.PRESC(P), .DEAD(D), .HOLD(H), .LZB(1)) dut (
      .clock(clock), .zera_n(zera_n),
      .req_a(req_a), .valor_a(valor_a), .req_b(req_b), .valor_b(valor_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .numero(numero), .digit_sel(digit_sel),
      .enable_n(enable_n), .fim_quadro(fim_quadro)
   );

   display_scan_scheduler #(.PRESC(P), .DEAD(D), .HOLD(H), .LZB(0)) dut0 (
      .clock(clock), .zera_n(zera_n),
      .req_a(req_a), .valor_a(valor_a), .req_b(req_b), .valor_b(valor_b),
      .gnt_a(gnt_a0), .gnt_b(gnt_b0), .numero(numero0), .digit_sel(digit_sel0),
      .enable_n(enable_n0), .fim_quadro(fim_quadro0)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
      end
   endtask

   function automatic int exp_en(bit lzb);
      int         q;
      int         slot;
      logic [3:0] e;
      if (!m_busy || m_pos == 0) return 15;
      q    = m_pos - 1;
      slot = q / SLOT;
      if (q % SLOT >= P) return 15;
      if (lzb && ((slot == 2 && m_num < 100) || (slot == 1 && m_num < 10))) return 15;
      e       = 4'b1111;
      e[slot] = 1'b0;
      return int'(e);
   endfunction

   task automatic arbitrate();
      bit ra, rb, own, oth;
      int w;
      ra = req_a;
      rb = req_b;
      w  = 0;
      if (m_owner != 0) begin
         own = (m_owner == 1) ? ra : rb;
         oth = (m_owner == 1) ? rb : ra;
         if (own && (m_shown < H || !oth)) begin
            w       = m_owner;
            m_shown = (m_shown >= H) ? 1 : m_shown + 1;
         end else if (oth) begin
            w       = 3 - m_owner;
            m_shown = 1;
         end
      end else begin
         if (ra && rb) w = (m_last == 1) ? 2 : 1;
         else if (ra)  w = 1;
         else if (rb)  w = 2;
         m_shown = 1;
      end
      if (w == 0) begin
         m_busy  = 0;
         m_owner = 0;
      end else begin
         m_owner = w;
         m_last  = w;
         m_num   = (w == 1) ? valor_a : valor_b;
         m_pos   = 1;
      end
   endtask

   task automatic model_edge();
      if (!zera_n) begin
         m_busy  = 0;
         m_pos   = 0;
         m_owner = 0;
         m_shown = 0;
         m_last  = 2;
         m_num   = 8'd0;
      end else if (!m_busy) begin
         if (req_a || req_b) begin
            m_busy = 1;
            m_pos  = 0;
         end
      end else if (m_pos == 0) begin
         arbitrate();
      end else begin
         m_pos = (m_pos == FRAME - 1) ? 0 : m_pos + 1;
      end
   endtask

   task automatic tick();
      int exp_digit;
      @(posedge clock);
      cycle++;
      model_edge();
      #1;
      exp_digit = (m_busy && m_pos >= 1) ? (m_pos - 1) / SLOT : 0;
      check("gnt_a",       int'(gnt_a),      int'(m_owner == 1));
      check("gnt_b",       int'(gnt_b),      int'(m_owner == 2));
      check("numero",      int'(numero),     int'(m_num));
      check("digit_sel",   int'(digit_sel),  exp_digit);
      check("enable_n",    int'(enable_n),   exp_en(1'b1));
      check("fim_quadro",  int'(fim_quadro), int'(m_busy && m_pos == FRAME - 1));
      check("enable_n_lz0", int'(enable_n0), exp_en(1'b0));
   endtask

   // Advance until the model reaches the given owner/position; bounded.
   task automatic run_to(input int owner, input int pos);
      int n;
      n = 0;
      while (!(m_busy && m_pos == pos && (owner == 0 || m_owner == owner)) && n < 6 * FRAME) begin
         tick();
         n++;
      end
      check("run_to_reached", int'(m_busy && m_pos == pos), 1);
   endtask

   initial begin
      // Reset held for a few cycles
      repeat (3) tick();
      zera_n = 1'b1;
      repeat (2) tick();

      // Single requester with three visible digits
      req_a   = 1'b1;
      valor_a = 8'd123;
      repeat (2 * FRAME + 2) tick();

      // Reset during digit-1 ON, then restart from IDLE
      run_to(1, 8);
      zera_n = 1'b0;
      tick();
      zera_n = 1'b1;
      repeat (FRAME + 3) tick();

      // Round-robin with both requesting
      req_b   = 1'b1;
      valor_a = 8'd200;
      valor_b = 8'd45;
      repeat (8 * FRAME) tick();

      // Leading-zero blanking
      req_b   = 1'b0;
      valor_a = 8'd7;
      repeat (3 * FRAME) tick();
      valor_a = 8'd42;
      repeat (2 * FRAME) tick();

      // Owner drops its request mid-frame while B waits, then B drops with nobody waiting
      run_to(1, 9);
      req_a   = 1'b0;
      req_b   = 1'b1;
      valor_b = 8'd99;
      repeat (FRAME + 2) tick();
      run_to(2, 9);
      req_b = 1'b0;
      repeat (FRAME + 4) tick();

      // Value change mid-frame must not tear the display
      req_a   = 1'b1;
      valor_a = 8'd10;
      run_to(1, 8);
      valor_a = 8'd250;
      repeat (2 * FRAME) tick();

      // Random traffic
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 15) == 0) req_a = ~req_a;
         if ($urandom_range(0, 15) == 0) req_b = ~req_b;
         valor_a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         valor_b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 120)) : 8'($urandom);
         zera_n  = ($urandom_range(0, 299) != 0);
         tick();
      end
      zera_n = 1'b1;
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scan_scheduler.md
Name: display_scan_scheduler

Overview:
- Sequences the multiplexed 3-digit 7-segment display path: binary-to-BCD converter, digit mux and segment decoder.
- Replaces the free-running digit counter with a timed scan: programmable on-time per digit, anti-ghosting dead time, and leading-zero blanking.
- Shares the display between two 8-bit value sources (A, B) through a round-robin, frame-granular request/grant arbiter.
- Values are latched only at frame boundaries, so a frame never shows digits from two different values.

Parameters:
PRESC, 50000, clock cycles each digit is lit (>=1)
DEAD, 16, clock cycles all digits off between digit slots (>=1)
HOLD, 64, full frames a grant lasts before re-arbitration (>=1)
LZB, 1, 1 = blank leading zeros of hundreds/tens; 0 = always show all 3 digits

Ports:
clock  in  1  system clock, all logic on rising edge
zera_n  in  1  synchronous active-low reset
req_a  in  1  source A requests the display (level)
valor_a  in  8  source A value (unsigned 0..255)
req_b  in  1  source B requests the display (level)
valor_b  in  8  source B value
gnt_a  out  1  A owns the display (registered)
gnt_b  out  1  B owns the display (registered); never both 1
numero  out  8  latched value driving the BCD converter
digit_sel  out  2  digit index to data mux: 0 = ones, 1 = tens, 2 = hundreds; value 3 is never driven
enable_n  out  4  active-low digit enables, bit i = digit i; bit 3 is always 1
fim_quadro  out  1  1-cycle pulse on the last cycle of each frame

Behaviour:
- Reset (zera_n=0 at an edge, any state): next cycle state=IDLE, gnt_a=gnt_b=0, numero=0, digit_sel=0, enable_n=4'b1111, fim_quadro=0, frame count=0, round-robin pointer=B (A wins the first tie). Reset overrides every other event.
- States: IDLE, ARB, ON, GAP.
- IDLE:
  - enable_n=1111, grants 0.
  - If req_a|req_b, go to ARB next cycle.
- ARB (1 cycle), arbitration:
  - Only one request: that source wins.
  - Both: the source not granted last wins.
  - None: clear grants and go to IDLE.
- ARB, with a winner:
  - Register gnt_x and latch numero<=valor_x.
  - Frame count is cleared on a new owner and incremented on the same owner.
  - Go to ON with digit_sel=0.
- Grant switching at ARB:
  - Same owner keeps the grant while its req holds and frame count<HOLD.
  - At HOLD frames the grant switches if the other source requests. Otherwise the same owner continues with count reset.
  - If the owner's req is low, the other source wins if it requests; else go to IDLE.
- ON (PRESC cycles):
  - enable_n drives bit digit_sel to 0, all others 1, unless the digit is blanked.
  - Blanking with LZB=1: digit 2 when numero<100; digit 1 when numero<10. Digit 0 is never blanked.
  - A blanked digit keeps enable_n=1111 for its whole slot; slot timing is unchanged.
- GAP (DEAD cycles):
  - enable_n=1111 and digit_sel is held.
  - At the end of GAP, digit_sel<2: increment digit_sel and go to ON.
  - At the end of GAP, digit_sel==2: set digit_sel=0, pulse fim_quadro on that last GAP cycle, go to ARB.
- Frame length = 1 + 3*(PRESC+DEAD) cycles.
- Mid-frame events:
  - valor_x changes and req drops are ignored until the next ARB.
  - The frame always completes with the latched numero and the current grant held.
- enable_n and digit_sel are registered: they change on the same edge as the state change, with no combinational glitch.
- Width rules: PRESC/DEAD counters use $clog2(max+1) bits; the frame counter saturates at HOLD.

Test Plan:
All scenarios use PRESC=4, DEAD=2, HOLD=2, LZB=1 (frame = 19 cycles).
1. Reset: only req_a=1, valor_a=123; then zera_n=0 for 1 cycle mid-ON of digit 1 -> next cycle enable_n=1111, gnt_a=0, numero=0; after zera_n=1: IDLE, then ARB, then the frame restarts at digit 0.
2. Single requester: req_a=1, valor_a=123 from IDLE -> gnt_a=1 and numero=123 after ARB. enable_n = 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011 x4, 1111 x2. fim_quadro pulses every 19 cycles; digit_sel goes 0,1,2.
3. Round-robin: req_a=req_b=1, valor_a=200, valor_b=45 -> A for 2 frames, B for 2, A for 2, ...; gnt_a&gnt_b never 1; numero alternates 200/45 at ARB only.
4. Blanking: valor_a=7 -> only the digit-0 slot shows 1110; digit-1/2 slots are 1111. valor_a=42 -> digits 0,1 lit, digit 2 blank. With LZB=0, valor_a=7 -> all 3 digits lit.
5. Request drop: A granted, req_a falls at mid-frame -> frame completes with gnt_a=1. If req_b=1 at ARB, gnt_b=1; if req_b=0, go to IDLE with enable_n=1111.
6. No tearing: valor_a changes 10→250 during digit-1 ON -> numero stays 10 until the next ARB, then reads 250.
